// File: rtl/uart_rx_port_if.sv
// CPU-side load bus of the UART receive port: address/strobe in, read data,
// decode hit and data-ready flag out.
interface uart_rx_port_if;
  logic [31:0] addr;
  logic        rd_en;
  logic [31:0] dataout;
  logic        hit;
  logic        rx_ready;

  modport master (output addr, output rd_en,
                  input  dataout, input hit, input rx_ready);
  modport slave  (input  addr, input rd_en,
                  output dataout, output hit, output rx_ready);
endinterface

// File: rtl/uart_rx_port.sv
// Memory-mapped 8N1 UART receiver feeding a byte FIFO. The CPU pops bytes by
// loading RX_ADDR and polls/clears sticky error flags through STAT_ADDR.
module uart_rx_port #(
  parameter int          CLKS_PER_BIT = 868,
  parameter int          PTR_W        = 11,
  parameter logic [31:0] RX_ADDR      = 32'ha00003f8,
  parameter logic [31:0] STAT_ADDR    = 32'ha00003fc
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rxd,
  uart_rx_port_if.slave bus
);

  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bidx_q;
  logic [7:0]       sh_q;
  logic             meta_q, rxs_q, rxs_prev_q;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic             ferr_q, ferr_d, ovr_q, ovr_d;
  logic [7:0]       mem_q [0:(1<<PTR_W)-1];

  logic stop_smp, push, frame_err, empty, full, wr_en, pop;
  logic rx_sel, st_sel, stat_clr;
  logic [31:0] dout;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      meta_q     <= rxd;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Frame FSM: mid-bit sampling, start-bit glitch rejection, LSB-first shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rxs_prev_q && !rxs_q) begin
            cnt_q   <= '0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == CNT_HALF) begin
            if (rxs_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= '0;
              bidx_q  <= '0;
              state_q <= DATA;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_q == CNT_FULL) begin
            sh_q[bidx_q] <= rxs_q;
            cnt_q        <= '0;
            if (bidx_q == 3'd7) state_q <= STOP;
            else                bidx_q  <= bidx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        STOP: begin
          // Back to IDLE at mid-stop so an immediately following start edge is seen.
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The push must land on the stop-sample edge itself, so it is decoded here.
  assign stop_smp  = (state_q == STOP) && (cnt_q == CNT_FULL);
  assign push      = stop_smp && rxs_q;
  assign frame_err = stop_smp && !rxs_q;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = ((wr_ptr_q + PTR_ONE) == rd_ptr_q);
  assign rx_sel   = (bus.addr == RX_ADDR);
  assign st_sel   = (bus.addr == STAT_ADDR);
  assign wr_en    = push && !full;
  // Empty is the pre-edge view, so a pop racing a push into an empty FIFO is a no-op.
  assign pop      = rx_sel && bus.rd_en && !empty;
  assign stat_clr = st_sel && bus.rd_en;

  // Pointer and sticky-flag next state; a set event beats a status-read clear.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ferr_d   = ferr_q;
    ovr_d    = ovr_q;
    if (wr_en)         wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)           rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (stat_clr)      begin ferr_d = 1'b0; ovr_d = 1'b0; end
    if (frame_err)     ferr_d = 1'b1;
    if (push && full)  ovr_d  = 1'b1;
  end

  // FIFO pointers and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // Byte storage; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= sh_q;
  end

  // Zero-wait-state read mux for the two mapped registers.
  always_comb begin
    dout = 32'h0;
    if (rx_sel && !empty) dout = {24'h0, mem_q[rd_ptr_q]};
    else if (st_sel)      dout = {29'h0, ferr_q, ovr_q, !empty};
  end

  assign bus.dataout  = dout;
  assign bus.hit      = rx_sel || st_sel;
  assign bus.rx_ready = !empty;

endmodule

// File: tb/tb_uart_rx_port.sv
// Bench for uart_rx_port: directed table, hand-written corner sequences, then
// random frames/reads checked against a queue-based model of the port.
module tb_uart_rx_port;
  localparam int          CPB = 16;
  localparam logic [31:0] RXA = 32'ha00003f8;
  localparam logic [31:0] STA = 32'ha00003fc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;
  uart_rx_port_if bus();

  uart_rx_port #(.CLKS_PER_BIT(CPB), .PTR_W(2), .RX_ADDR(RXA), .STAT_ADDR(STA))
    dut (.clk(clk), .rst(rst), .rxd(rxd), .bus(bus));

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
    rxd = 1'b1;
  endtask

  task automatic cpu_read(input logic [31:0] a, input logic en,
                          output logic [31:0] d, output logic h);
    @(negedge clk);
    bus.addr  = a;
    bus.rd_en = en;
    #1;
    d = bus.dataout;
    h = bus.hit;
    @(posedge clk);
    #1;
    bus.rd_en = 1'b0;
    bus.addr  = 32'h0;
  endtask

  // Reference model: FIFO of 3 usable bytes plus two sticky flags.
  logic [7:0] q[$];
  logic       m_ferr = 1'b0;
  logic       m_ovr  = 1'b0;

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop)            m_ferr = 1'b1;
    else if (q.size() == 3) m_ovr = 1'b1;
    else                  q.push_back(d);
  endtask

  typedef struct {
    int          kind;   // 0 send frame, 1 read data, 2 read status
    logic [7:0]  d;
    logic        stp;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input int k, input logic [7:0] d, input logic s,
                              input logic [31:0] e);
    vec_t v;
    v.kind = k; v.d = d; v.stp = s; v.exp = e;
    tbl.push_back(v);
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic        h;
    bus.addr  = 32'h0;
    bus.rd_en = 1'b0;

    // single byte
    add(0, 8'h55, 1'b1, 0);
    add(1, 0, 0, 32'h55);
    add(2, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0);
    // framing error
    add(0, 8'hA3, 1'b0, 0);
    add(2, 0, 0, 32'h4);
    add(2, 0, 0, 32'h0);
    add(1, 0, 0, 32'h0);
    // overrun at capacity 3
    add(0, 8'h01, 1'b1, 0);
    add(0, 8'h02, 1'b1, 0);
    add(0, 8'h03, 1'b1, 0);
    add(0, 8'h04, 1'b1, 0);
    add(2, 0, 0, 32'h3);
    add(1, 0, 0, 32'h01);
    add(1, 0, 0, 32'h02);
    add(1, 0, 0, 32'h03);
    add(1, 0, 0, 32'h0);
    add(2, 0, 0, 32'h0);

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    #1 chk("reset rx_ready", {31'h0, bus.rx_ready}, 32'h0);
    cpu_read(RXA, 1'b0, d, h);    chk("reset rx data", d, 32'h0); chk("reset rx hit", {31'h0, h}, 32'h1);
    cpu_read(STA, 1'b0, d, h);    chk("reset status", d, 32'h0);  chk("reset st hit", {31'h0, h}, 32'h1);
    cpu_read(32'h0, 1'b0, d, h);  chk("reset unmapped", d, 32'h0); chk("reset unmapped hit", {31'h0, h}, 32'h0);

    // directed table
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].kind == 0) begin
        send_frame(tbl[i].d, tbl[i].stp);
      end else begin
        cpu_read(tbl[i].kind == 1 ? RXA : STA, 1'b1, d, h);
        chk($sformatf("tbl[%0d]", i), d, tbl[i].exp);
      end
    end

    // glitch rejection: 4-cycle low pulse
    @(negedge clk);
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    chk("glitch rx_ready", {31'h0, bus.rx_ready}, 32'h0);
    cpu_read(STA, 1'b1, d, h); chk("glitch status", d, 32'h0);
    send_frame(8'h3C, 1'b1);
    cpu_read(RXA, 1'b1, d, h); chk("post-glitch frame", d, 32'h3C);

    // pop on the exact push edge with one byte already held
    send_frame(8'h11, 1'b1);
    fork
      send_frame(8'h22, 1'b1);
      begin
        @(negedge clk);
        repeat (154) @(posedge clk);
        @(negedge clk);
        bus.addr  = RXA;
        bus.rd_en = 1'b1;
        #1 chk("simul pop old byte", bus.dataout, 32'h11);
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        bus.addr  = 32'h0;
        chk("simul rx_ready held", {31'h0, bus.rx_ready}, 32'h1);
      end
    join
    cpu_read(RXA, 1'b1, d, h); chk("simul new byte", d, 32'h22);
    cpu_read(STA, 1'b1, d, h); chk("simul status", d, 32'h0);

    // reset during data bit 4 with one byte queued
    send_frame(8'h99, 1'b1);
    @(negedge clk);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h5A >> i));
    rxd = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst rx_ready", {31'h0, bus.rx_ready}, 32'h0);
    cpu_read(STA, 1'b0, d, h); chk("midrst status", d, 32'h0);
    cpu_read(RXA, 1'b1, d, h); chk("midrst rx data", d, 32'h0);
    repeat (20) @(negedge clk);
    send_frame(8'h7E, 1'b1);
    cpu_read(RXA, 1'b1, d, h); chk("midrst next frame", d, 32'h7E);
    cpu_read(STA, 1'b1, d, h); chk("midrst final status", d, 32'h0);

    // random traffic against the model (starts empty, flags clear)
    q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    for (int it = 0; it < 60; it++) begin
      int unsigned r;
      logic [31:0] e;
      logic        en;
      r  = $urandom_range(0, 9);
      en = 1'($urandom_range(0, 1));
      if (r <= 3) begin
        logic [7:0] b;
        logic       s;
        b = 8'($urandom);
        s = ($urandom_range(0, 7) != 0);
        send_frame(b, s);
        model_frame(b, s);
      end else if (r <= 6) begin
        e = (q.size() != 0) ? {24'h0, q[0]} : 32'h0;
        cpu_read(RXA, (r == 6) ? 1'b0 : 1'b1, d, h);
        if (r != 6 && q.size() != 0) void'(q.pop_front());
        chk($sformatf("rnd[%0d] data", it), d, e);
        chk($sformatf("rnd[%0d] data hit", it), {31'h0, h}, 32'h1);
      end else if (r <= 8) begin
        e = {29'h0, m_ferr, m_ovr, q.size() != 0};
        cpu_read(STA, en, d, h);
        if (en) begin m_ferr = 1'b0; m_ovr = 1'b0; end
        chk($sformatf("rnd[%0d] status", it), d, e);
      end else begin
        logic [31:0] a;
        a = $urandom;
        if (a == RXA || a == STA) a = 32'h1000;
        cpu_read(a, en, d, h);
        chk($sformatf("rnd[%0d] unmapped", it), {d[31:1], d[0] | h}, 32'h0);
      end
      chk($sformatf("rnd[%0d] rx_ready", it), {31'h0, bus.rx_ready}, {31'h0, q.size() != 0});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver: the receive-side counterpart of the CPU's transmit port at 0xa00003f8. It deserialises 8N1 frames from the host's serial line into a byte FIFO. The CPU drains the FIFO by reading the port address and polls a status register for data-ready and error flags. The block sits beside the data-memory device decoder and returns read data for its own addresses only.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clk cycles per bit (100 MHz / 115200); must be even and ≥ 8.
- `PTR_W`, default 11: FIFO pointer width; storage is 2^PTR_W bytes, usable capacity 2^PTR_W − 1.
- `RX_ADDR`, default 32'ha00003f8: data register; a read pops one byte.
- `STAT_ADDR`, default 32'ha00003fc: status register; a read clears the sticky flags.

Ports:
- `clk`, in, 1: single clock; all state is updated on posedge.
- `rst`, in, 1: synchronous, active-high reset.
- `rxd`, in, 1: asynchronous serial input; idles high.
- `addr`, in, 32: CPU data address.
- `rd_en`, in, 1: CPU load strobe, valid for one cycle per access.
- `dataout`, out, 32: read data; combinational from `addr` and current state.
- `hit`, out, 1: high when `addr` equals `RX_ADDR` or `STAT_ADDR`; the outer mux selects `dataout` on this.
- `rx_ready`, out, 1: FIFO non-empty; usable as an interrupt/LED.

## Operation
- **Synchroniser:** 2-flop synchroniser on `rxd`, both flops reset to 1. The FSM sees only the synced bit `rxs` and its previous value.
- **FSM states:** IDLE, START, DATA, STOP. One counter `cnt` counts bit time; `bidx` (3 bits) indexes the data bit.
- **IDLE:** on a falling edge of `rxs` (prev 1, now 1→0), load `cnt`=0 and go to START.
- **START:** at `cnt`==CLKS_PER_BIT/2−1, sample `rxs`.
  - If 1: glitch; return to IDLE with no side effects.
  - If 0: clear `cnt`, set `bidx`=0, go to DATA.
- **DATA:** at `cnt`==CLKS_PER_BIT−1, shift `rxs` into bit `bidx` of the shift register (LSB first) and clear `cnt`. After `bidx`==7, go to STOP.
- **STOP:** at `cnt`==CLKS_PER_BIT−1, sample `rxs`.
  - If 1: push the byte.
  - If 0: set sticky `ferr` and discard the byte.
  - Either way, go to IDLE. A held-low line does not retrigger; IDLE needs a fresh falling edge.
- **FIFO:** `wr_ptr` and `rd_ptr` are PTR_W bits and wrap naturally.
  - empty = (`wr_ptr`==`rd_ptr`); full = (`wr_ptr`+1==`rd_ptr`).
  - A push when full (pre-edge value) drops the byte and sets sticky `ovr`, even if a pop occurs in the same cycle.
- **Data read:** when `addr`==RX_ADDR, `dataout`={24'b0, fifo[`rd_ptr`]} if non-empty, else 32'h0. If `rd_en` is also high and the FIFO is non-empty, `rd_ptr` increments at the edge. An empty read never moves `rd_ptr`.
- **Status read:** when `addr`==STAT_ADDR, `dataout`={29'b0, `ferr`, `ovr`, `rx_ready`}. With `rd_en`, `ferr` and `ovr` clear at the edge. A set event in the same cycle wins over the clear.
- **Unmapped address:** `dataout`=0 and `hit`=0.
- **Simultaneous events:** push and pop in one cycle both take effect. A pop from empty with a simultaneous push returns 0 and does not pop, and the pushed byte remains.

## Timing
- **Reset values:** FSM=IDLE, `cnt`=0, `bidx`=0, pointers=0, `ferr`=`ovr`=0, synchroniser=1, `rx_ready`=0. `dataout` follows the rules above, so it is 0 for all addresses immediately after reset.
- **Reset mid-frame:** the partial byte is discarded and the FIFO is emptied.
- **Frame latency:** let T0 be the edge at which IDLE detects the falling edge (2–3 cycles after the pin falls).
  - Start bit sampled at T0+CLKS_PER_BIT/2.
  - Data bit i sampled at T0+CLKS_PER_BIT/2+(i+1)·CLKS_PER_BIT.
  - Stop bit sampled, and the byte pushed, at T0+CLKS_PER_BIT/2+9·CLKS_PER_BIT.
  - `rx_ready` rises the cycle after the push.
- **Back-to-back frames:** a frame whose start edge immediately follows the stop bit is received; IDLE is re-entered by mid-stop-bit.
- **CPU reads:** zero wait states. `dataout` is valid in the same cycle as `addr`; the pop or flag-clear takes effect at that cycle's edge.

## Test plan
- **Single byte:** CLKS_PER_BIT=16; send 0x55, then read RX_ADDR. Expect 0x00000055, then `rx_ready`=0, and a second read returns 0.
- **Glitch rejection:** pulse `rxd` low for 4 cycles at CLKS_PER_BIT=16. Expect no push, no flags, and FSM back in IDLE.
- **Framing error:** send 0xA3 with the stop bit low. Expect the FIFO to stay empty and status to read 0x4. A second status read returns 0x0.
- **Overrun:** PTR_W=2; send 0x01–0x04 without reading. Expect status 0x3, FIFO reads 0x01, 0x02, 0x03, then empty (0x04 dropped).
- **Simultaneous push/pop:** with the FIFO holding one byte, pop on the exact push cycle. Expect the old byte returned, the new byte retained, and `rx_ready` held at 1.
- **Reset mid-frame:** assert `rst` during bit 4 of a frame. Expect all outputs at reset values. The next full frame, 0x7E, is received correctly.
